// File: rtl/video_timing_gen.sv
// Raster timing generator: registered syncs, data-enable, active coordinates and line/frame pulses.
// Optional colour-bar output is built when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          ref_clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [23:0]   rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam longint unsigned COORD_RANGE = 64'd1 << CW;

  if (COORD_RANGE < 64'(H_TOTAL) || COORD_RANGE < 64'(V_TOTAL) ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
    $error("video_timing_gen: zero timing parameter or CW too narrow for totals");
  end

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          first_q, first_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Outputs decode the current (h,v); the counters then move to the next position.
  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    first_d       = first_q;
    frame_cnt_d   = frame_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (en) begin
      de_d          = (h_q < H_ACT) && (v_q < V_ACT);
      x_d           = de_d ? h_q : '0;
      y_d           = de_d ? v_q : '0;
      hsync_d       = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
      // The frame counter counts completed frames, so the very first frame start is skipped.
      if (frame_start_d) begin
        if (first_q) begin
          first_d = 1'b0;
        end else begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      first_q       <= 1'b1;
      frame_cnt_q   <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      first_q       <= first_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef VTG_TEST_PATTERN_EN
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic [23:0] rgb_q, rgb_d;
  logic [31:0] bar_idx;

  // Bars are indexed by the same h that feeds x, so colour lines up with de.
  always_comb begin
    bar_idx = 32'(h_q) / BAR_DIV;
    rgb_d   = rgb_q;
    if (en) begin
      rgb_d = 24'h000000;
      if ((BAR_W > 0) && (h_q < H_ACT) && (v_q < V_ACT) && (bar_idx < 32'd8)) begin
        rgb_d = BAR_RGB[bar_idx[2:0]];
      end
    end
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three configurations checked per clock against a position-arithmetic model.
// Build with VTG_TEST_PATTERN_EN defined to also check the colour-bar output.
module tb_video_timing_gen;

  typedef struct {
    int hAct; int hFp; int hSync; int hBp;
    int vAct; int vFp; int vSync; int vBp;
    bit hPol; bit vPol;
  } cfg_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] fc;
    logic [23:0] rgb;
  } obs_t;

  logic ref_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;

  logic        dHs, dVs, dDe, dLs, dFs;
  logic [11:0] dX, dY;
  logic [15:0] dFc;
  logic        mHs, mVs, mDe, mLs, mFs;
  logic [5:0]  mX, mY;
  logic [15:0] mFc;
  logic        tHs, tVs, tDe, tLs, tFs;
  logic [3:0]  tX, tY;
  logic [15:0] tFc;
`ifdef VTG_TEST_PATTERN_EN
  logic [23:0] dRgb, mRgb, tRgb;
`endif

  int checks = 0;
  int errors = 0;
  int k = 0;
  cfg_t cfgs [3];

  always #5 ref_clk = ~ref_clk;

  video_timing_gen dutDefault (
    .ref_clk(ref_clk), .rst_n(rst_n), .en(en),
    .hsync(dHs), .vsync(dVs), .de(dDe), .x(dX), .y(dY),
    .line_start(dLs), .frame_start(dFs), .frame_cnt(dFc)
`ifdef VTG_TEST_PATTERN_EN
    , .rgb(dRgb)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(6)
  ) dutMedium (
    .ref_clk(ref_clk), .rst_n(rst_n), .en(en),
    .hsync(mHs), .vsync(mVs), .de(mDe), .x(mX), .y(mY),
    .line_start(mLs), .frame_start(mFs), .frame_cnt(mFc)
`ifdef VTG_TEST_PATTERN_EN
    , .rgb(mRgb)
`endif
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
  ) dutTiny (
    .ref_clk(ref_clk), .rst_n(rst_n), .en(en),
    .hsync(tHs), .vsync(tVs), .de(tDe), .x(tX), .y(tY),
    .line_start(tLs), .frame_start(tFs), .frame_cnt(tFc)
`ifdef VTG_TEST_PATTERN_EN
    , .rgb(tRgb)
`endif
  );

  // Expected outputs after kk enabled edges since reset: position is simply (kk-1) mod frame size.
  function automatic obs_t model(input cfg_t c, input int kk);
    obs_t o;
    int ht, vt, p, h, v;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    o = '0;
    o.hs = ~c.hPol;
    o.vs = ~c.vPol;
    if (kk == 0) return o;
    ht = c.hAct + c.hFp + c.hSync + c.hBp;
    vt = c.vAct + c.vFp + c.vSync + c.vBp;
    p = (kk - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    o.de = (h < c.hAct) && (v < c.vAct);
    if (o.de) begin
      o.x = 12'(h);
      o.y = 12'(v);
    end
    o.hs = (h >= c.hAct + c.hFp && h < c.hAct + c.hFp + c.hSync) ? c.hPol : ~c.hPol;
    o.vs = (v >= c.vAct + c.vFp && v < c.vAct + c.vFp + c.vSync) ? c.vPol : ~c.vPol;
    o.ls = (h == 0);
    o.fs = (p == 0);
    o.fc = 16'((kk - 1) / (ht * vt));
`ifdef VTG_TEST_PATTERN_EN
    if (o.de && (c.hAct / 8) > 0 && (h / (c.hAct / 8)) < 8) o.rgb = bars[h / (c.hAct / 8)];
`endif
    return o;
  endfunction

  function automatic obs_t getObs(input int d);
    obs_t o;
    o = '0;
    case (d)
      0: begin
        o.hs = dHs; o.vs = dVs; o.de = dDe; o.ls = dLs; o.fs = dFs;
        o.x = dX; o.y = dY; o.fc = dFc;
`ifdef VTG_TEST_PATTERN_EN
        o.rgb = dRgb;
`endif
      end
      1: begin
        o.hs = mHs; o.vs = mVs; o.de = mDe; o.ls = mLs; o.fs = mFs;
        o.x = {6'b0, mX}; o.y = {6'b0, mY}; o.fc = mFc;
`ifdef VTG_TEST_PATTERN_EN
        o.rgb = mRgb;
`endif
      end
      default: begin
        o.hs = tHs; o.vs = tVs; o.de = tDe; o.ls = tLs; o.fs = tFs;
        o.x = {8'b0, tX}; o.y = {8'b0, tY}; o.fc = tFc;
`ifdef VTG_TEST_PATTERN_EN
        o.rgb = tRgb;
`endif
      end
    endcase
    return o;
  endfunction

  // One clock with the given enable; outputs are then sampled 1 time unit after the edge.
  task automatic applyStimulus(input bit e);
    en = e;
    @(posedge ref_clk);
    if (e && rst_n) k++;
    #1;
  endtask

  task automatic doReset();
    @(negedge ref_clk);
    rst_n = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    @(negedge ref_clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    obs_t act, exp;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0]);
      for (int d = 0; d < 3; d++) begin
        act = getObs(d);
        exp = model(cfgs[d], 0);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL reset_state dut%0d cyc%0d got %h want %h", d, i, act, exp);
        end
      end
    end
    @(negedge ref_clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_continuous();
    obs_t act, exp;
    int firstLow = -1, lowCount = 0, firstBlank = -1;
    int lastFs = -1, fsSeen = 0;
    for (int i = 1; i <= 2000; i++) begin
      applyStimulus(1'b1);
      for (int d = 0; d < 3; d++) begin
        act = getObs(d);
        exp = model(cfgs[d], k);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL continuous dut%0d edge%0d got %h want %h", d, k, act, exp);
        end
      end
      if (i == 1) begin
        checks++;
        if ({dDe, dFs, dLs, dX, dY, dFc} !== {3'b111, 12'd0, 12'd0, 16'd0}) begin
          errors++;
          $display("[TB] FAIL first_edge got de=%b fs=%b ls=%b x=%0d y=%0d fc=%0d want 1 1 1 0 0 0",
                   dDe, dFs, dLs, dX, dY, dFc);
        end
      end
      if (i <= 800) begin
        if (!dHs) begin
          lowCount++;
          if (firstLow < 0) firstLow = i - 1;
        end
        if (!dDe && firstBlank < 0) firstBlank = i - 1;
      end
      if (mFs) begin
        fsSeen++;
        if (lastFs >= 0) begin
          checks++;
          if (i - lastFs !== 570) begin
            errors++;
            $display("[TB] FAIL frame_period got %0d want 570", i - lastFs);
          end
        end
        if (fsSeen == 2) begin
          checks++;
          if (mFc !== 16'd1) begin
            errors++;
            $display("[TB] FAIL frame_cnt_second got %0d want 1", mFc);
          end
        end
        lastFs = i;
      end
    end
    checks++;
    if (firstLow !== 656 || lowCount !== 96) begin
      errors++;
      $display("[TB] FAIL hsync_window got start=%0d len=%0d want 656 96", firstLow, lowCount);
    end
    checks++;
    if (firstBlank !== 640) begin
      errors++;
      $display("[TB] FAIL de_end got %0d want 640", firstBlank);
    end
  endtask

  task automatic test_en_toggle();
    obs_t act, exp;
    bit e;
    doReset();
    for (int i = 0; i < 3500; i++) begin
      if (i < 1500) e = ~i[0];
      else if (i < 2500) e = ($urandom_range(0, 3) != 0);
      else e = ($urandom_range(0, 3) == 0);
      applyStimulus(e);
      for (int d = 0; d < 3; d++) begin
        act = getObs(d);
        exp = model(cfgs[d], k);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL en_toggle dut%0d cyc%0d en=%b got %h want %h", d, i, e, act, exp);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t act, exp;
    int target;
    doReset();
    target = $urandom_range(3000, 6000);
    while (k < target) applyStimulus(($urandom_range(0, 4) != 0));
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      act = getObs(d);
      exp = model(cfgs[d], 0);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("[TB] FAIL async_reset dut%0d got %h want %h", d, act, exp);
      end
    end
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    @(negedge ref_clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'b1);
      for (int d = 0; d < 3; d++) begin
        act = getObs(d);
        exp = model(cfgs[d], k);
        checks++;
        if (act !== exp) begin
          errors++;
          $display("[TB] FAIL restart dut%0d edge%0d got %h want %h", d, k, act, exp);
        end
      end
    end
  endtask

  initial begin
    cfgs[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfgs[1] = '{20, 2, 3, 5, 12, 2, 2, 3, 1'b1, 1'b0};
    cfgs[2] = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0};
    test_reset();
    test_continuous();
    test_en_toggle();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
